// File: rtl/wishbone_pkg.sv
// Shared Wishbone types for the arbiter and later interconnect blocks.
// Address fields are sized for the widest bus; narrower users zero-extend.
package wishbone_pkg;

    localparam int WB_ADR_MAX = 64;
    localparam int WB_DAT_W   = 32;
    localparam int WB_SEL_W   = 4;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        M0   = 2'd1,
        M1   = 2'd2
    } owner_t;

    typedef struct packed {
        logic                  cyc;
        logic                  stb;
        logic                  we;
        logic [WB_ADR_MAX-1:0] adr;
        logic [WB_SEL_W-1:0]   sel;
        logic [WB_DAT_W-1:0]   dat;
    } wb_req_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                ack;
        logic                err;
        logic                rty;
    } wb_rsp_t;

    // Counter width that holds 0..t; a disabled watchdog still gets one bit.
    function automatic int wd_cnt_width(input int t);
        return (t > 0) ? $clog2(t + 1) : 1;
    endfunction

endpackage

// File: rtl/wishbone_watchdog.sv
// Counts cycles of an unanswered strobe and pulses fire for one cycle when
// the slave has been silent for TIMEOUT_CYCLES cycles. TIMEOUT_CYCLES=0 disables it.
module wishbone_watchdog
    import wishbone_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic active,
    input  logic terminated,
    output logic fire
);

    generate
        if (TIMEOUT_CYCLES == 0) begin : g_off
            logic w_unused;
            assign w_unused = clk_i ^ rst_i ^ active ^ terminated;
            assign fire     = 1'b0;
        end else begin : g_on
            localparam int            CW      = wd_cnt_width(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] LIMIT   = CW'(TIMEOUT_CYCLES);
            localparam logic [CW-1:0] FIRE_AT = CW'(TIMEOUT_CYCLES - 1);

            logic [CW-1:0] r_cnt;
            logic          r_fire;

            always_ff @(posedge clk_i or negedge rst_i) begin
                if (!rst_i) begin
                    r_cnt  <= '0;
                    r_fire <= 1'b0;
                end else begin
                    r_fire <= active && !terminated && (r_cnt == FIRE_AT);
                    if (r_fire || !active || terminated)
                        r_cnt <= '0;
                    else if (r_cnt != LIMIT)
                        r_cnt <= r_cnt + 1'b1;
                end
            end

            assign fire = r_fire;
        end
    endgenerate

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master / one-slave Wishbone arbiter: round-robin per bus cycle, grant held
// for the whole cyc, combinational routing once granted, watchdog-forced err.
module wishbone_arbiter
    import wishbone_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int ADDR_WIDTH     = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  m0_cyc_i,
    input  logic                  m0_stb_i,
    input  logic                  m0_we_i,
    input  logic [ADDR_WIDTH-1:0] m0_adr_i,
    input  logic [3:0]            m0_sel_i,
    input  logic [31:0]           m0_dat_i,
    output logic [31:0]           m0_dat_o,
    output logic                  m0_ack_o,
    output logic                  m0_err_o,
    output logic                  m0_rty_o,
    input  logic                  m1_cyc_i,
    input  logic                  m1_stb_i,
    input  logic                  m1_we_i,
    input  logic [ADDR_WIDTH-1:0] m1_adr_i,
    input  logic [3:0]            m1_sel_i,
    input  logic [31:0]           m1_dat_i,
    output logic [31:0]           m1_dat_o,
    output logic                  m1_ack_o,
    output logic                  m1_err_o,
    output logic                  m1_rty_o,
    output logic                  s_cyc_o,
    output logic                  s_stb_o,
    output logic                  s_we_o,
    output logic [ADDR_WIDTH-1:0] s_adr_o,
    output logic [3:0]            s_sel_o,
    output logic [31:0]           s_dat_o,
    input  logic [31:0]           s_dat_i,
    input  logic                  s_ack_i,
    input  logic                  s_err_i,
    input  logic                  s_rty_i,
    output logic [1:0]            grant_o,
    output logic                  timeout_o
);

    owner_t  r_owner, w_owner_nxt;
    logic    r_last,  w_last_nxt;
    wb_req_t w_m0, w_m1, w_req;
    wb_rsp_t w_rsp, w_rsp0, w_rsp1;
    logic    w_active, w_term, w_fire, w_unused_adr;

    always_comb begin
        w_m0     = '0;
        w_m0.cyc = m0_cyc_i;
        w_m0.stb = m0_stb_i;
        w_m0.we  = m0_we_i;
        w_m0.sel = m0_sel_i;
        w_m0.dat = m0_dat_i;
        w_m0.adr[ADDR_WIDTH-1:0] = m0_adr_i;
        w_m1     = '0;
        w_m1.cyc = m1_cyc_i;
        w_m1.stb = m1_stb_i;
        w_m1.we  = m1_we_i;
        w_m1.sel = m1_sel_i;
        w_m1.dat = m1_dat_i;
        w_m1.adr[ADDR_WIDTH-1:0] = m1_adr_i;
    end

    // Request seen by the slave is selected only by the registered owner,
    // so an idle bus never exposes a master's cyc combinationally.
    always_comb begin
        case (r_owner)
            M0:      w_req = w_m0;
            M1:      w_req = w_m1;
            default: w_req = '0;
        endcase
    end

    // Re-arbitrate whenever the current owner is not holding cyc; this gives
    // zero-dead-cycle handover when the other master is already waiting.
    always_comb begin
        w_owner_nxt = r_owner;
        w_last_nxt  = r_last;
        if (!w_req.cyc) begin
            if (m0_cyc_i && (!m1_cyc_i || r_last)) begin
                w_owner_nxt = M0;
                w_last_nxt  = 1'b0;
            end else if (m1_cyc_i) begin
                w_owner_nxt = M1;
                w_last_nxt  = 1'b1;
            end else begin
                w_owner_nxt = IDLE;
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_owner <= IDLE;
            r_last  <= 1'b1;
        end else begin
            r_owner <= w_owner_nxt;
            r_last  <= w_last_nxt;
        end
    end

    assign w_active = w_req.cyc & w_req.stb;
    assign w_term   = s_ack_i | s_err_i | s_rty_i;

    wishbone_watchdog #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_wd (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .active     (w_active),
        .terminated (w_term),
        .fire       (w_fire)
    );

    // A forced timeout masks any late slave termination in the same cycle.
    always_comb begin
        w_rsp.dat = s_dat_i;
        w_rsp.ack = s_ack_i & ~w_fire;
        w_rsp.err = s_err_i | w_fire;
        w_rsp.rty = s_rty_i & ~w_fire;
    end

    assign w_rsp0 = (r_owner == M0) ? w_rsp : '0;
    assign w_rsp1 = (r_owner == M1) ? w_rsp : '0;

    assign m0_dat_o = w_rsp0.dat;
    assign m0_ack_o = w_rsp0.ack;
    assign m0_err_o = w_rsp0.err;
    assign m0_rty_o = w_rsp0.rty;
    assign m1_dat_o = w_rsp1.dat;
    assign m1_ack_o = w_rsp1.ack;
    assign m1_err_o = w_rsp1.err;
    assign m1_rty_o = w_rsp1.rty;

    assign s_cyc_o = w_req.cyc;
    assign s_stb_o = w_req.stb & ~w_fire;
    assign s_we_o  = w_req.we;
    assign s_adr_o = w_req.adr[ADDR_WIDTH-1:0];
    assign s_sel_o = w_req.sel;
    assign s_dat_o = w_req.dat;

    assign w_unused_adr = ^w_req.adr;

    assign grant_o   = {r_owner == M1, r_owner == M0};
    assign timeout_o = w_fire;

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench: a small registered slave with a 4-word swapped flash image,
// one arbiter with a 4-cycle watchdog and one with the watchdog disabled.
module tb_wishbone_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    always #5 clk_i = ~clk_i;

    logic        m0_cyc_i, m0_stb_i, m0_we_i, m1_cyc_i, m1_stb_i, m1_we_i;
    logic [31:0] m0_adr_i, m0_dat_i, m1_adr_i, m1_dat_i;
    logic [3:0]  m0_sel_i, m1_sel_i;
    logic [31:0] m0_dat_o, m1_dat_o, s_adr_o, s_dat_o, s_dat_i;
    logic        m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o;
    logic        s_cyc_o, s_stb_o, s_we_o, s_ack_i, s_err_i, s_rty_i, timeout_o;
    logic [3:0]  s_sel_o;
    logic [1:0]  grant_o;

    logic [31:0] b_m0_dat_o, b_m1_dat_o, b_s_adr_o, b_s_dat_o;
    logic        b_m0_ack_o, b_m0_err_o, b_m0_rty_o, b_m1_ack_o, b_m1_err_o, b_m1_rty_o;
    logic        b_s_cyc_o, b_s_stb_o, b_s_we_o, b_timeout_o;
    logic [3:0]  b_s_sel_o;
    logic [1:0]  b_grant_o;

    int checks = 0;
    int errors = 0;

    wishbone_arbiter #(.TIMEOUT_CYCLES(4), .ADDR_WIDTH(32)) dut (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(m0_dat_o),
        .m0_ack_o(m0_ack_o), .m0_err_o(m0_err_o), .m0_rty_o(m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(m1_dat_o),
        .m1_ack_o(m1_ack_o), .m1_err_o(m1_err_o), .m1_rty_o(m1_rty_o),
        .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o), .s_we_o(s_we_o), .s_adr_o(s_adr_o),
        .s_sel_o(s_sel_o), .s_dat_o(s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(grant_o), .timeout_o(timeout_o)
    );

    wishbone_arbiter #(.TIMEOUT_CYCLES(0), .ADDR_WIDTH(32)) dut_nowd (
        .clk_i(clk_i), .rst_i(rst_i),
        .m0_cyc_i(m0_cyc_i), .m0_stb_i(m0_stb_i), .m0_we_i(m0_we_i), .m0_adr_i(m0_adr_i),
        .m0_sel_i(m0_sel_i), .m0_dat_i(m0_dat_i), .m0_dat_o(b_m0_dat_o),
        .m0_ack_o(b_m0_ack_o), .m0_err_o(b_m0_err_o), .m0_rty_o(b_m0_rty_o),
        .m1_cyc_i(m1_cyc_i), .m1_stb_i(m1_stb_i), .m1_we_i(m1_we_i), .m1_adr_i(m1_adr_i),
        .m1_sel_i(m1_sel_i), .m1_dat_i(m1_dat_i), .m1_dat_o(b_m1_dat_o),
        .m1_ack_o(b_m1_ack_o), .m1_err_o(b_m1_err_o), .m1_rty_o(b_m1_rty_o),
        .s_cyc_o(b_s_cyc_o), .s_stb_o(b_s_stb_o), .s_we_o(b_s_we_o), .s_adr_o(b_s_adr_o),
        .s_sel_o(b_s_sel_o), .s_dat_o(b_s_dat_o), .s_dat_i(s_dat_i),
        .s_ack_i(s_ack_i), .s_err_i(s_err_i), .s_rty_i(s_rty_i),
        .grant_o(b_grant_o), .timeout_o(b_timeout_o)
    );

    // Slave: flash words 0x00-0x0C answer with ack one cycle after stb, 0x20 errs,
    // 0x24 retries, everything else never answers. Read data comes back byte-swapped.
    function automatic logic [31:0] flash_swapped(input logic [1:0] i);
        case (i)
            2'd0:    return 32'h7654_3210;
            2'd1:    return 32'h0102_0304;
            2'd2:    return 32'hAABB_CCDD;
            default: return 32'hBBAA_9988;
        endcase
    endfunction

    logic w_hit;
    assign w_hit = s_cyc_o && s_stb_o && !(s_ack_i || s_err_i || s_rty_i);

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            s_ack_i <= 1'b0;
            s_err_i <= 1'b0;
            s_rty_i <= 1'b0;
            s_dat_i <= '0;
        end else begin
            s_ack_i <= w_hit && (s_adr_o < 32'h10);
            s_err_i <= w_hit && (s_adr_o == 32'h20);
            s_rty_i <= w_hit && (s_adr_o == 32'h24);
            s_dat_i <= (w_hit && !s_we_o && s_adr_o < 32'h10) ? flash_swapped(s_adr_o[3:2]) : '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic m_set(input int m, input logic cyc, input logic stb, input logic we,
                         input logic [31:0] adr, input logic [3:0] sel, input logic [31:0] dat);
        if (m == 0) begin
            m0_cyc_i = cyc; m0_stb_i = stb; m0_we_i = we; m0_adr_i = adr; m0_sel_i = sel; m0_dat_i = dat;
        end else begin
            m1_cyc_i = cyc; m1_stb_i = stb; m1_we_i = we; m1_adr_i = adr; m1_sel_i = sel; m1_dat_i = dat;
        end
    endtask

    task automatic m_idle(input int m);
        m_set(m, 1'b0, 1'b0, 1'b0, 32'h0, 4'h0, 32'h0);
    endtask

    task automatic do_reset();
        rst_i = 1'b0;
        m_idle(0);
        m_idle(1);
        tick();
        tick();
        rst_i = 1'b1;
    endtask

    // Watch the next negedges for a termination on master m; kind is {rty,err,ack}.
    // The other master must see no termination meanwhile.
    task automatic wait_term(input int m, input logic [2:0] kind, input logic [31:0] dat, input string tag);
        bit got;
        got = 1'b0;
        for (int i = 0; i < 12 && !got; i++) begin
            @(negedge clk_i);
            if (m == 0) begin
                chk({tag, "_other_quiet"}, {31'd0, m1_ack_o | m1_err_o | m1_rty_o}, 32'd0);
                if (m0_ack_o | m0_err_o | m0_rty_o) begin
                    got = 1'b1;
                    chk({tag, "_kind"}, {29'd0, m0_rty_o, m0_err_o, m0_ack_o}, {29'd0, kind});
                    chk({tag, "_dat"}, m0_dat_o, dat);
                end
            end else begin
                chk({tag, "_other_quiet"}, {31'd0, m0_ack_o | m0_err_o | m0_rty_o}, 32'd0);
                if (m1_ack_o | m1_err_o | m1_rty_o) begin
                    got = 1'b1;
                    chk({tag, "_kind"}, {29'd0, m1_rty_o, m1_err_o, m1_ack_o}, {29'd0, kind});
                    chk({tag, "_dat"}, m1_dat_o, dat);
                end
            end
        end
        chk({tag, "_seen"}, {31'd0, got}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_time_limit: got expired expected finish");
        $fatal(1, "time limit");
    end

    initial begin
        int n, pulses, acnt, bcnt;
        bit fired;
        m_idle(0);
        m_idle(1);
        #1 rst_i = 1'b0;
        m_set(0, 1'b1, 1'b1, 1'b1, 32'h1234, 4'hF, 32'hDEAD_BEEF);
        m_set(1, 1'b1, 1'b1, 1'b1, 32'h5678, 4'hF, 32'hCAFE_CAFE);
        #12;
        chk("rst_grant", {30'd0, grant_o}, 32'd0);
        chk("rst_s_ctl", {29'd0, s_cyc_o, s_stb_o, s_we_o}, 32'd0);
        chk("rst_s_adr", s_adr_o, 32'd0);
        chk("rst_s_dat_sel", s_dat_o | {28'd0, s_sel_o}, 32'd0);
        chk("rst_m_rsp", {26'd0, m0_ack_o, m0_err_o, m0_rty_o, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);
        chk("rst_m_dat", m0_dat_o | m1_dat_o, 32'd0);
        chk("rst_timeout", {31'd0, timeout_o}, 32'd0);
        m_idle(0);
        m_idle(1);
        tick();
        rst_i = 1'b1;
        tick();

        // Single master read, then err and rty pass-through
        tick(); m_set(0, 1'b1, 1'b1, 1'b0, 32'h4, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("t1_grant_wait", {30'd0, grant_o}, 32'd0);
        chk("t1_s_cyc_idle", {31'd0, s_cyc_o}, 32'd0);
        tick(); @(negedge clk_i);
        chk("t1_grant", {30'd0, grant_o}, 32'd1);
        chk("t1_s_stb", {31'd0, s_stb_o}, 32'd1);
        chk("t1_s_adr", s_adr_o, 32'h4);
        wait_term(0, 3'b001, 32'h0102_0304, "t1_rd");
        chk("t1_m1_dat", m1_dat_o, 32'd0);
        tick(); m_set(0, 1'b1, 1'b1, 1'b0, 32'h20, 4'hF, 32'h0);
        wait_term(0, 3'b010, 32'h0, "t1_err");
        tick(); m_set(0, 1'b1, 1'b1, 1'b0, 32'h24, 4'hF, 32'h0);
        wait_term(0, 3'b100, 32'h0, "t1_rty");
        tick(); m_idle(0);
        @(negedge clk_i);
        chk("t1_release_s_cyc", {31'd0, s_cyc_o}, 32'd0);
        tick(); @(negedge clk_i);
        chk("t1_idle_grant", {30'd0, grant_o}, 32'd0);

        // Tie after reset, handover without a dead cycle, repeat tie
        do_reset();
        tick();
        m_set(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        m_set(1, 1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("t2_grant_wait", {30'd0, grant_o}, 32'd0);
        tick(); @(negedge clk_i);
        chk("t2_first_m0", {30'd0, grant_o}, 32'd1);
        wait_term(0, 3'b001, 32'h7654_3210, "t2_m0");
        tick(); m_idle(0);
        @(negedge clk_i);
        chk("t2_hand_a", {30'd0, grant_o}, 32'd1);
        tick(); @(negedge clk_i);
        chk("t2_hand_b", {30'd0, grant_o}, 32'd2);
        chk("t2_m1_adr", s_adr_o, 32'h8);
        wait_term(1, 3'b001, 32'hAABB_CCDD, "t2_m1");
        tick(); m_idle(1);
        tick();
        m_set(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        m_set(1, 1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        @(negedge clk_i);
        chk("t2_idle_before_retie", {30'd0, grant_o}, 32'd0);
        tick(); @(negedge clk_i);
        chk("t2_retie_m0", {30'd0, grant_o}, 32'd1);
        tick(); m_idle(0); m_idle(1);
        tick(); tick();

        // m1 holds the bus for three reads while m0 waits with a write
        tick(); m_set(1, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        tick(); m_set(0, 1'b1, 1'b1, 1'b1, 32'h8, 4'hC, 32'hCAFE_F00D);
        @(negedge clk_i);
        chk("t3_grant_m1", {30'd0, grant_o}, 32'd2);
        wait_term(1, 3'b001, 32'h7654_3210, "t3_rd0");
        tick(); m1_adr_i = 32'h4;
        wait_term(1, 3'b001, 32'h0102_0304, "t3_rd1");
        tick(); m1_adr_i = 32'hC;
        wait_term(1, 3'b001, 32'hBBAA_9988, "t3_rd2");
        tick(); m_idle(1);
        @(negedge clk_i);
        chk("t3_m1_tail", {30'd0, grant_o}, 32'd2);
        tick(); @(negedge clk_i);
        chk("t3_m0_grant", {30'd0, grant_o}, 32'd1);
        chk("t3_wr_ctl", {27'd0, s_we_o, s_sel_o}, {27'd0, 1'b1, 4'hC});
        chk("t3_wr_dat", s_dat_o, 32'hCAFE_F00D);
        wait_term(0, 3'b001, 32'h0, "t3_wr");
        tick(); m_idle(0);
        tick(); tick();

        // Watchdog (4 cycles) on an unmapped address
        tick(); m_set(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0);
        tick(); @(negedge clk_i);
        chk("t4_grant", {30'd0, grant_o}, 32'd1);
        chk("t4_s_stb", {31'd0, s_stb_o}, 32'd1);
        n = 0;
        fired = 1'b0;
        for (int i = 0; i < 10 && !fired; i++) begin
            @(negedge clk_i);
            n++;
            if (timeout_o) begin
                fired = 1'b1;
                chk("t4_fire_stb", {31'd0, s_stb_o}, 32'd0);
                chk("t4_fire_rsp", {29'd0, m0_rty_o, m0_err_o, m0_ack_o}, 32'b010);
                chk("t4_fire_grant", {30'd0, grant_o}, 32'd1);
            end
        end
        chk("t4_fired", {31'd0, fired}, 32'd1);
        chk("t4_latency", n, 32'd4);
        tick(); m_idle(0);
        pulses = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk_i);
            pulses += int'(timeout_o | m0_err_o);
        end
        chk("t4_once", pulses, 32'd0);

        // Watchdog disabled: 100 cycles of silence never produce err
        tick(); m_set(0, 1'b1, 1'b1, 1'b0, 32'hFFFF_0000, 4'hF, 32'h0);
        acnt = 0;
        bcnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk_i);
            bcnt += int'(b_timeout_o | b_m0_err_o);
            acnt += int'(timeout_o);
        end
        chk("t5_nowd_quiet", bcnt, 32'd0);
        chk("t5_nowd_grant", {30'd0, b_grant_o}, 32'd1);
        chk("t5_wd_refires", acnt, 32'd19);
        tick(); m_idle(0);
        tick(); tick();

        // Asynchronous reset in the middle of an m1 transfer
        tick(); m_set(1, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        tick(); @(negedge clk_i);
        chk("t6_grant_m1", {30'd0, grant_o}, 32'd2);
        #2 rst_i = 1'b0;
        #1;
        chk("t6_async_s", {30'd0, s_cyc_o, s_stb_o}, 32'd0);
        chk("t6_async_grant", {28'd0, grant_o, b_grant_o}, 32'd0);
        chk("t6_no_term", {29'd0, m1_ack_o, m1_err_o, m1_rty_o}, 32'd0);
        m_set(0, 1'b1, 1'b1, 1'b0, 32'h0, 4'hF, 32'h0);
        m_set(1, 1'b1, 1'b1, 1'b0, 32'h8, 4'hF, 32'h0);
        tick(); tick();
        rst_i = 1'b1;
        @(negedge clk_i);
        chk("t6_post_idle", {30'd0, grant_o}, 32'd0);
        tick(); @(negedge clk_i);
        chk("t6_tie_m0", {30'd0, grant_o}, 32'd1);
        tick(); m_idle(0); m_idle(1);
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/wishbone_arbiter.md
Name: wishbone_arbiter

Overview:
Two-master to one-slave big-endian Wishbone arbiter. It shares the flash emulator, or any other single Wishbone slave, between the CPU instruction-fetch port (master 0) and the data port (master 1). Ownership is round-robin, granted per bus cycle and held for the whole `cyc` cycle. A watchdog terminates transfers the slave never answers with `err`. Data is passed through unmodified; no byte swapping.

Parameters:
- `TIMEOUT_CYCLES`, 16, number of cycles of unanswered `stb&cyc` before the arbiter forces `err`; 0 disables the watchdog.
- `ADDR_WIDTH`, 32, width of the address buses.

Ports:
- `clk_i`  input  1  clock, all logic on rising edge
- `rst_i`  input  1  asynchronous, active-low reset
- `mN_cyc_i`, `mN_stb_i`, `mN_we_i` (N=0,1)  input  1 each  master N bus cycle, strobe, write enable
- `mN_adr_i`  input  `ADDR_WIDTH`  master N address
- `mN_sel_i`  input  4  master N byte selects
- `mN_dat_i`  input  32  master N write data
- `mN_dat_o`  output  32  master N read data
- `mN_ack_o`, `mN_err_o`, `mN_rty_o`  output  1 each  master N termination
- `s_cyc_o`, `s_stb_o`, `s_we_o`  output  1 each  slave controls
- `s_adr_o`  output  `ADDR_WIDTH`  slave address
- `s_sel_o`  output  4  slave byte selects
- `s_dat_o`  output  32  slave write data
- `s_dat_i`  input  32  slave read data
- `s_ack_i`, `s_err_i`, `s_rty_i`  input  1 each  slave termination
- `grant_o`  output  2  one-hot current owner; 00 when idle
- `timeout_o`  output  1  one-cycle pulse when the watchdog fires

Behaviour:
- State register `owner` with values IDLE, M0, M1. Also:
  - `last` (1 bit): last master granted.
  - `wd_cnt`: $clog2(`TIMEOUT_CYCLES`+1) bits.
  - `wd_fire` (1 bit).
- Reset (`rst_i`=0, takes effect immediately):
  - `owner`=IDLE, `last`=1, `wd_cnt`=0, `wd_fire`=0.
  - All outputs are 0, including `s_cyc_o`, `s_stb_o` and the data buses.
  - A reset mid-transfer abandons the transfer; no termination is reported.
- Arbitration, evaluated every edge where `owner`=IDLE, or where the owner has `cyc_i`=0:
  - Only one `mN_cyc_i` high: that master is granted.
  - Both high: grant the master ≠ `last`.
  - Neither high: IDLE.
  - The new owner is registered, so the grant is visible the cycle after the request. Latency from an idle bus is one cycle.
  - Handover directly between owners is allowed with no dead cycle: the owner drops `cyc` at edge k, and the other master owns the bus from cycle k+1.
  - `last` updates whenever a grant is issued.
- Routing while owner=MN (combinational from `owner`):
  - `s_*_o` follow master N's `cyc`, `stb`, `we`, `adr`, `sel` and `dat`.
  - `mN_dat_o`, `ack`, `err` and `rty` follow the slave.
  - The non-owner sees `dat_o`=0 and `ack`/`err`/`rty`=0, and its request is held off.
  - In IDLE all `s_*_o` are 0.
- Watchdog (`TIMEOUT_CYCLES`>0):
  - `wd_cnt` clears on the owner's `stb`=0, or on any of `s_ack_i`/`s_err_i`/`s_rty_i`.
  - Otherwise it increments while owner `stb&cyc`, saturating at `TIMEOUT_CYCLES`.
  - When `wd_cnt`==`TIMEOUT_CYCLES`-1 and no termination is present, `wd_fire` is set for the next cycle.
  - While `wd_fire`=1:
    - `s_stb_o` is forced 0.
    - Owner `err_o`=1, with `ack_o`=0 and `rty_o`=0.
    - `timeout_o`=1.
    - `wd_cnt` clears.
  - `wd_fire` self-clears after one cycle. Ownership is unaffected; the master decides whether to drop `cyc`.
  - A slave termination arriving in the same cycle as `wd_fire` is masked, and only `err` is seen.
- Owner drops `cyc` while `stb` is pending: the grant is released at that edge, and `wd_cnt` clears.
- No combinational path from `mN_cyc_i` to `s_cyc_o` while IDLE. Once granted, the path from the master to the slave is combinational; no added pipeline stage.

Decomposition:
- Shared package `wishbone_pkg`:
  - `owner_t` enum {IDLE, M0, M1}.
  - A `wb_req_t` struct (cyc, stb, we, adr, sel, dat) and a `wb_rsp_t` struct (dat, ack, err, rty).
  - Used by the arbiter and future interconnect blocks.
- One sub-module, `wishbone_watchdog`: the counter plus fire pulse, parameterised by `TIMEOUT_CYCLES`, with inputs `active`, `terminated` and output `fire`.

Test Plan:
1. Only m0 reads 0x0000_0004 from `flash_emulator` (BASE 0) → `grant_o`=01 the cycle after `cyc`; `m0_ack_o`=1 with `m0_dat_o` = byte-swapped flash[1]; m1 outputs stay 0.
2. m0 and m1 both raise `cyc` in the same cycle after reset → m0 is granted first. When m0 drops `cyc`, m1 is granted the next cycle (`grant_o` 01→10, no 00 cycle). A repeat tie is granted to m0.
3. m1 holds `cyc` for 3 back-to-back reads while m0 requests → m0 is stalled (`ack`=0) until m1 drops `cyc`; all 3 m1 reads return correct data.
4. `TIMEOUT_CYCLES`=4, m0 accesses address 0xFFFF_0000 (unmapped) → `m0_err_o` and `timeout_o` pulse exactly once, 4 cycles after `stb`; `s_stb_o`=0 in that cycle; `grant_o` stays 01.
5. `TIMEOUT_CYCLES`=0 with an unmapped access held 100 cycles → no `err`, no `timeout_o`.
6. Assert `rst_i`=0 asynchronously, mid-cycle, during an m1 transfer → `s_cyc_o`, `s_stb_o` and `grant_o` go to 0 without waiting for a clock edge. After release, the first tie goes to m0.
